// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline event counter: FSM encoding,
// read-select codes and status word bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_CYCLE  = 2'b00;
    localparam logic [1:0] SEL_STALL  = 2'b01;
    localparam logic [1:0] SEL_FLUSH  = 2'b10;
    localparam logic [1:0] SEL_STATUS = 2'b11;

    localparam int STAT_RUN_BIT  = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_SAT_BIT  = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    assign sat_o = &cnt_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && !sat_o) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/pipe_event_counter.sv
// Run/stall/flush cycle monitor for the 5-stage pipeline with a cycle budget
// and a registered read port.
//
// state | meaning
// IDLE  | counters hold, waiting for start_i
// RUN   | counting every cycle with start_i high
// DONE  | budget reached, counters frozen until clr_i/rst_i
module pipe_event_counter
    import cpu_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             hd_stall_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             eq_i,
    input  logic             clr_i,
    input  logic [1:0]       rd_sel_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             done_o,
    output logic             running_o
);

    // One extra bit so a budget wider than the counter can never match.
    localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(CYCLE_LIMIT);

    state_t state_q, state_d;

    logic stall_ev, flush_ev, count_en, limit_hit;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, cycle_nxt;
    logic cycle_sat, stall_sat, flush_sat;
    logic [CNT_W-1:0] rd_data_d;

    // A control-transfer in ID overrides a hazard stall in the accounting.
    assign stall_ev = hd_stall_i & ~jump_i & ~branch_i;
    assign flush_ev = jump_i | (branch_i & eq_i);

    assign count_en  = (state_q == ST_RUN) && start_i && !clr_i;
    assign cycle_nxt = cycle_sat ? cycle_cnt : cycle_cnt + CNT_W'(1);
    assign limit_hit = (CYCLE_LIMIT != 0) && ({1'b0, cycle_nxt} == LIMIT);

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .inc_i (count_en),
        .cnt_o (cycle_cnt),
        .sat_o (cycle_sat)
    );

    sat_counter #(.W(CNT_W)) u_stall (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .inc_i (count_en && stall_ev),
        .cnt_o (stall_cnt),
        .sat_o (stall_sat)
    );

    sat_counter #(.W(CNT_W)) u_flush (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .inc_i (count_en && flush_ev),
        .cnt_o (flush_cnt),
        .sat_o (flush_sat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_RUN;
                ST_RUN: begin
                    if (!start_i) begin
                        state_d = ST_IDLE;
                    end else if (limit_hit) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign running_o = (state_q == ST_RUN);
    assign done_o    = (state_q == ST_DONE);

    always_comb begin
        rd_data_d = '0;
        case (rd_sel_i)
            SEL_CYCLE: rd_data_d = cycle_cnt;
            SEL_STALL: rd_data_d = stall_cnt;
            SEL_FLUSH: rd_data_d = flush_cnt;
            default: begin
                rd_data_d[STAT_RUN_BIT]  = (state_q == ST_RUN);
                rd_data_d[STAT_DONE_BIT] = (state_q == ST_DONE);
                rd_data_d[STAT_SAT_BIT]  = cycle_sat | stall_sat | flush_sat;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_event_counter.sv
// Scoreboard bench: two instances (32-bit/limit 30 and 4-bit/unlimited) share
// stimulus; a behavioural model queues expectations checked by a monitor.
module tb_pipe_event_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, hd_stall, jump, branch, eq, clr;
    logic [1:0] rd_sel;
    logic [31:0] rd_a;
    logic        done_a, run_a;
    logic [3:0]  rd_b;
    logic        done_b, run_b;

    pipe_event_counter #(.CNT_W(32), .CYCLE_LIMIT(30)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .hd_stall_i(hd_stall),
        .jump_i(jump), .branch_i(branch), .eq_i(eq), .clr_i(clr),
        .rd_sel_i(rd_sel), .rd_data_o(rd_a), .done_o(done_a), .running_o(run_a)
    );

    pipe_event_counter #(.CNT_W(4), .CYCLE_LIMIT(0)) dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(start), .hd_stall_i(hd_stall),
        .jump_i(jump), .branch_i(branch), .eq_i(eq), .clr_i(clr),
        .rd_sel_i(rd_sel), .rd_data_o(rd_b), .done_o(done_b), .running_o(run_b)
    );

    typedef struct {
        int     idx;
        longint rd;
        bit     done;
        bit     running;
    } exp_t;

    exp_t sbq[$];
    int tests = 0;
    int fails = 0;

    // Reference model: counts indexed 0 cycle, 1 stall, 2 flush.
    // Phase names: "IDLE", "RUN", "DONE".
    longint m_cnt[2][3];
    string  m_phase[2];
    longint m_max[2] = '{64'hFFFF_FFFF, 64'd15};
    int     m_lim[2] = '{30, 0};

    function automatic longint bump(longint v, longint mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_edge(input int i);
        exp_t   e;
        longint rd;
        bit     any_sat, st_ev, fl_ev;
        any_sat = 1'b0;
        for (int k = 0; k < 3; k++) if (m_cnt[i][k] == m_max[i]) any_sat = 1'b1;
        if (rd_sel == 2'd3)
            rd = longint'(m_phase[i] == "RUN") + 2 * longint'(m_phase[i] == "DONE")
                 + 4 * longint'(any_sat);
        else
            rd = m_cnt[i][rd_sel];
        st_ev = hd_stall && !jump && !branch;
        fl_ev = jump || (branch && eq);
        if (rst || clr) begin
            if (rst) rd = 0;
            for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
            m_phase[i] = "IDLE";
        end else if (m_phase[i] == "IDLE") begin
            if (start) m_phase[i] = "RUN";
        end else if (m_phase[i] == "RUN") begin
            if (!start) begin
                m_phase[i] = "IDLE";
            end else begin
                m_cnt[i][0] = bump(m_cnt[i][0], m_max[i]);
                if (st_ev) m_cnt[i][1] = bump(m_cnt[i][1], m_max[i]);
                if (fl_ev) m_cnt[i][2] = bump(m_cnt[i][2], m_max[i]);
                if (m_lim[i] != 0 && m_cnt[i][0] == m_lim[i]) m_phase[i] = "DONE";
            end
        end
        e.idx = i;
        e.rd = rd;
        e.done = (m_phase[i] == "DONE");
        e.running = (m_phase[i] == "RUN");
        sbq.push_back(e);
    endtask

    task automatic check(input string name, input int idx, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s[inst%0d] t=%0t actual=%0d required=%0d", name, idx, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.idx == 0) begin
                    check("rd_data", 0, longint'(rd_a), e.rd);
                    check("done", 0, longint'(done_a), longint'(e.done));
                    check("running", 0, longint'(run_a), longint'(e.running));
                end else begin
                    check("rd_data", 1, longint'(rd_b), e.rd);
                    check("done", 1, longint'(done_b), longint'(e.done));
                    check("running", 1, longint'(run_b), longint'(e.running));
                end
            end
        end
    end

    task automatic step(input bit r, input bit c, input bit s, input bit h,
                        input bit j, input bit b, input bit q, input logic [1:0] sel);
        @(negedge clk);
        rst = r; clr = c; start = s; hd_stall = h; jump = j; branch = b; eq = q; rd_sel = sel;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
    endtask

    function automatic logic [1:0] rsel();
        return 2'($urandom_range(3));
    endfunction

    initial begin : driver
        rst = 1'b1; clr = 1'b0; start = 1'b0; hd_stall = 1'b0;
        jump = 1'b0; branch = 1'b0; eq = 1'b0; rd_sel = 2'd0;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = "IDLE";
            for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
        end

        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 2'd3);
        // Quiet run to the budget, then poke all inputs while DONE.
        repeat (31) step(0, 0, 1, 0, 0, 0, 0, rsel());
        step(0, 0, 1, 0, 0, 0, 0, 2'd0);
        repeat (6) step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom),
                        1'($urandom), 1'($urandom), rsel());
        step(0, 0, 0, 0, 0, 0, 0, 2'd3);

        // Event mix: 3 stalls, jump, taken branch, not-taken branch.
        step(0, 1, 1, 0, 0, 0, 0, 2'd3);
        step(0, 0, 1, 0, 0, 0, 0, 2'd3);
        repeat (3) step(0, 0, 1, 1, 0, 0, 0, rsel());
        step(0, 0, 1, 0, 1, 0, 0, rsel());
        step(0, 0, 1, 0, 0, 1, 1, rsel());
        step(0, 0, 1, 0, 0, 1, 0, rsel());
        step(0, 0, 0, 0, 0, 0, 0, 2'd1);
        step(0, 0, 0, 0, 0, 0, 0, 2'd2);
        step(0, 0, 0, 0, 0, 0, 0, 2'd0);
        step(0, 0, 1, 0, 0, 0, 0, 2'd2);
        step(0, 0, 1, 1, 0, 1, 1, 2'd2);
        step(0, 0, 1, 0, 0, 0, 0, 2'd2);
        step(0, 0, 1, 0, 0, 0, 0, 2'd1);

        // Pause at cycle 10 for 4 cycles, then resume to the budget.
        step(0, 1, 0, 0, 0, 0, 0, 2'd0);
        repeat (11) step(0, 0, 1, 0, 0, 0, 0, 2'd0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 2'd0);
        repeat (22) step(0, 0, 1, 0, 0, 0, 0, rsel());

        // Reset in the middle of a run.
        step(0, 1, 0, 0, 0, 0, 0, 2'd3);
        repeat (6) step(0, 0, 1, 1'($urandom), 0, 0, 0, rsel());
        step(1, 0, 1, 1, 1, 1, 1, 2'd0);
        step(0, 0, 0, 0, 0, 0, 0, 2'd3);

        repeat (500) begin
            step(($urandom_range(99) == 0), ($urandom_range(59) == 0),
                 ($urandom_range(99) < 88), 1'($urandom), ($urandom_range(9) == 0),
                 ($urandom_range(5) == 0), 1'($urandom), rsel());
        end

        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL sb_drain actual=%0d required=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
